// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the imem request/ack handshake and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds a saturating REDIRECT_CNT output.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] NEXT_PC,
    input  logic        REDIRECT,
    input  logic        STALL,
    output logic        IMEM_REQ,
    output logic [15:0] IMEM_ADDR,
    input  logic [15:0] IMEM_RDATA,
    input  logic        IMEM_ACK,
    output logic [15:0] PC,
    output logic [15:0] INSTR,
    output logic        INSTR_VALID,
    output logic        FETCH_ERR
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] REDIRECT_CNT
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD,
        ST_ERROR
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        fetch_err_q, fetch_err_d;
    logic        accept;
    logic        imem_req;

    assign accept = !instr_valid_q || !STALL;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        hold_d        = hold_q;
        wait_cnt_d    = wait_cnt_q;
        fetch_err_d   = fetch_err_q;
        imem_req      = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (REDIRECT) begin
                    fetch_pc_d    = NEXT_PC;
                    instr_valid_d = 1'b0;
                    hold_d        = '0;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                // Redirect wins over stall and a same-cycle ack; the acked word is wrong-path.
                if (REDIRECT) begin
                    fetch_pc_d    = NEXT_PC;
                    instr_valid_d = 1'b0;
                    hold_d        = '0;
                    wait_cnt_d    = '0;
                end else if (IMEM_ACK) begin
                    wait_cnt_d = '0;
                    if (accept) begin
                        pc_d          = fetch_pc_q;
                        instr_d       = IMEM_RDATA;
                        instr_valid_d = 1'b1;
                        fetch_pc_d    = fetch_pc_q + 16'd1;
                    end else begin
                        hold_d  = IMEM_RDATA;
                        state_d = ST_HOLD;
                    end
                end else begin
                    if (accept) begin
                        instr_valid_d = 1'b0;
                    end
                    if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_d  = '0;
                        fetch_err_d = 1'b1;
                        state_d     = ST_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ST_HOLD: begin
                wait_cnt_d = '0;
                if (REDIRECT) begin
                    fetch_pc_d    = NEXT_PC;
                    instr_valid_d = 1'b0;
                    hold_d        = '0;
                    state_d       = ST_FETCH;
                end else if (!STALL) begin
                    pc_d          = fetch_pc_q;
                    instr_d       = hold_q;
                    instr_valid_d = 1'b1;
                    fetch_pc_d    = fetch_pc_q + 16'd1;
                    state_d       = ST_FETCH;
                end
            end
            ST_ERROR: begin
                instr_valid_d = 1'b0;
                wait_cnt_d    = '0;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (REDIRECT && state_q != ST_ERROR && redirect_cnt_q != 16'hFFFF) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            redirect_cnt_q <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign REDIRECT_CNT = redirect_cnt_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_PC;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            hold_q        <= '0;
            wait_cnt_q    <= '0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            hold_q        <= hold_d;
            wait_cnt_q    <= wait_cnt_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign IMEM_REQ    = imem_req;
    assign IMEM_ADDR   = fetch_pc_q;
    assign PC          = pc_q;
    assign INSTR       = instr_q;
    assign INSTR_VALID = instr_valid_q;
    assign FETCH_ERR   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard of expected fetch PCs is popped whenever decode consumes IF/ID.
// Build with FETCH_PERF_CNT_EN defined to also exercise REDIRECT_CNT.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] NEXT_PC = '0;
    logic        REDIRECT = 1'b0;
    logic        STALL = 1'b0;
    logic        IMEM_REQ;
    logic [15:0] IMEM_ADDR;
    logic [15:0] IMEM_RDATA;
    logic        IMEM_ACK;
    logic [15:0] PC;
    logic [15:0] INSTR;
    logic        INSTR_VALID;
    logic        FETCH_ERR;
    logic        ack_en = 1'b0;

    logic        rst_w = 1'b1;
    logic        req_w;
    logic [15:0] addr_w;
    logic [15:0] pc_w;
    logic [15:0] instr_w;
    logic        valid_w;
    logic        err_w;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] REDIRECT_CNT;
    logic [15:0] redirect_cnt_w;
`endif

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] exp_q[$];

    always #5 CLK = ~CLK;

    // Zero-wait memory model: word content is a fixed function of its address.
    assign IMEM_ACK   = ack_en;
    assign IMEM_RDATA = IMEM_ADDR ^ 16'hA5A5;

    fetch_unit #(.RESET_PC(16'h0000), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RST(RST), .NEXT_PC(NEXT_PC), .REDIRECT(REDIRECT), .STALL(STALL),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA), .IMEM_ACK(IMEM_ACK),
        .PC(PC), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .FETCH_ERR(FETCH_ERR)
`ifdef FETCH_PERF_CNT_EN
        , .REDIRECT_CNT(REDIRECT_CNT)
`endif
    );

    fetch_unit #(.RESET_PC(16'hFFFE), .MAX_WAIT(15)) dut_w (
        .CLK(CLK), .RST(rst_w), .NEXT_PC(16'h0000), .REDIRECT(1'b0), .STALL(1'b0),
        .IMEM_REQ(req_w), .IMEM_ADDR(addr_w), .IMEM_RDATA(addr_w ^ 16'hA5A5), .IMEM_ACK(1'b1),
        .PC(pc_w), .INSTR(instr_w), .INSTR_VALID(valid_w), .FETCH_ERR(err_w)
`ifdef FETCH_PERF_CNT_EN
        , .REDIRECT_CNT(redirect_cnt_w)
`endif
    );

    // Advance one cycle; decode consumes IF/ID when valid and not stalled, which pops the scoreboard.
    task automatic tick();
        logic [15:0] exp_pc;
        @(negedge CLK);
        if (!RST && INSTR_VALID && !STALL) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL sb_extra: got pc=%h instr=%h, required no instruction", PC, INSTR);
            end else begin
                exp_pc = exp_q.pop_front();
                if (PC !== exp_pc) begin
                    tests_failed++;
                    $display("[TB] FAIL sb_pc: got %h, required %h", PC, exp_pc);
                end
                tests_run++;
                if (INSTR !== (exp_pc ^ 16'hA5A5)) begin
                    tests_failed++;
                    $display("[TB] FAIL sb_instr: got %h, required %h", INSTR, exp_pc ^ 16'hA5A5);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REDIRECT = 1'b0;
        STALL = 1'b0;
        exp_q.delete();
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic check_drained(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        ack_en = 1'b1;
        do_reset();
        tests_run++;
        if (IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0 || FETCH_ERR !== 1'b0 || PC !== 16'h0 || INSTR !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got req=%b valid=%b err=%b pc=%h instr=%h, required 0 0 0 0000 0000",
                     IMEM_REQ, INSTR_VALID, FETCH_ERR, PC, INSTR);
        end
        tick();
        tests_run++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL boot_req: got req=%b addr=%h, required 1 0000", IMEM_REQ, IMEM_ADDR);
        end
        ack_en = 1'b0;
    endtask

    task automatic test_stream();
        ack_en = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (INSTR_VALID !== 1'b1 || PC !== 16'(i)) begin
                tests_failed++;
                $display("[TB] FAIL stream_%0d: got valid=%b pc=%h, required 1 %h", i, INSTR_VALID, PC, 16'(i));
            end
        end
        ack_en = 1'b0;
        tick();
        tick();
        check_drained("stream");
    endtask

    task automatic test_stall_hold();
        ack_en = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
        tick();
        tick();
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b1 || PC !== 16'h0000 || INSTR !== 16'hA5A5) begin
                tests_failed++;
                $display("[TB] FAIL hold_%0d: got req=%b valid=%b pc=%h instr=%h, required 0 1 0000 a5a5",
                         i, IMEM_REQ, INSTR_VALID, PC, INSTR);
            end
        end
        STALL = 1'b0;
        tick();
        tests_run++;
        if (INSTR_VALID !== 1'b1 || PC !== 16'h0001 || INSTR !== (16'h0001 ^ 16'hA5A5)) begin
            tests_failed++;
            $display("[TB] FAIL hold_release: got valid=%b pc=%h instr=%h, required 1 0001 a5a4",
                     INSTR_VALID, PC, INSTR);
        end
        tick();
        tick();
        ack_en = 1'b0;
        tick();
        tick();
        check_drained("hold");
    endtask

    task automatic test_redirect();
        ack_en = 1'b1;
        do_reset();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0041);
        tick();
        tick();
        tick();
        STALL = 1'b1;
        REDIRECT = 1'b1;
        NEXT_PC = 16'h0040;
        tick();
        REDIRECT = 1'b0;
        STALL = 1'b0;
        tests_run++;
        if (INSTR_VALID !== 1'b0 || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 16'h0040) begin
            tests_failed++;
            $display("[TB] FAIL redirect_flush: got valid=%b req=%b addr=%h, required 0 1 0040",
                     INSTR_VALID, IMEM_REQ, IMEM_ADDR);
        end
        tick();
        tests_run++;
        if (INSTR_VALID !== 1'b1 || PC !== 16'h0040) begin
            tests_failed++;
            $display("[TB] FAIL redirect_target: got valid=%b pc=%h, required 1 0040", INSTR_VALID, PC);
        end
        tick();
        ack_en = 1'b0;
        tick();
        tick();
        check_drained("redirect");
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pcs [3];
        exp_pcs[0] = 16'hFFFE;
        exp_pcs[1] = 16'hFFFF;
        exp_pcs[2] = 16'h0000;
        RST = 1'b1;
        rst_w = 1'b1;
        tick();
        tick();
        rst_w = 1'b0;
        tick();
        tests_run++;
        if (req_w !== 1'b1 || addr_w !== 16'hFFFE) begin
            tests_failed++;
            $display("[TB] FAIL wrap_first_req: got req=%b addr=%h, required 1 fffe", req_w, addr_w);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (valid_w !== 1'b1 || pc_w !== exp_pcs[i] || instr_w !== (exp_pcs[i] ^ 16'hA5A5)) begin
                tests_failed++;
                $display("[TB] FAIL wrap_%0d: got valid=%b pc=%h instr=%h, required 1 %h %h",
                         i, valid_w, pc_w, instr_w, exp_pcs[i], exp_pcs[i] ^ 16'hA5A5);
            end
        end
        rst_w = 1'b1;
    endtask

    task automatic test_timeout();
        ack_en = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (IMEM_REQ !== 1'b1 || FETCH_ERR !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL wait_%0d: got req=%b err=%b, required 1 0", i, IMEM_REQ, FETCH_ERR);
            end
        end
        tick();
        tests_run++;
        if (FETCH_ERR !== 1'b1 || IMEM_REQ !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout: got err=%b req=%b, required 1 0", FETCH_ERR, IMEM_REQ);
        end
        REDIRECT = 1'b1;
        NEXT_PC = 16'h0040;
        tick();
        REDIRECT = 1'b0;
        tick();
        tests_run++;
        if (FETCH_ERR !== 1'b1 || IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL error_sticky: got err=%b req=%b valid=%b, required 1 0 0",
                     FETCH_ERR, IMEM_REQ, INSTR_VALID);
        end
        do_reset();
        tests_run++;
        if (FETCH_ERR !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL error_clear: got err=%b, required 0", FETCH_ERR);
        end
        tick();
        tests_run++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL restart: got req=%b addr=%h, required 1 0000", IMEM_REQ, IMEM_ADDR);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        ack_en = 1'b0;
        do_reset();
        tests_run++;
        if (REDIRECT_CNT !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL cnt_reset: got %0d, required 0", REDIRECT_CNT);
        end
        for (int i = 0; i < 5; i++) begin
            REDIRECT = 1'b1;
            NEXT_PC = 16'h0100;
            tick();
            REDIRECT = 1'b0;
            tick();
        end
        tests_run++;
        if (REDIRECT_CNT !== 16'd5) begin
            tests_failed++;
            $display("[TB] FAIL cnt_five: got %0d, required 5", REDIRECT_CNT);
        end
        for (int i = 0; i < 5; i++) tick();
        REDIRECT = 1'b1;
        tick();
        REDIRECT = 1'b0;
        tick();
        tests_run++;
        if (FETCH_ERR !== 1'b1 || REDIRECT_CNT !== 16'd5) begin
            tests_failed++;
            $display("[TB] FAIL cnt_in_error: got err=%b cnt=%0d, required 1 5", FETCH_ERR, REDIRECT_CNT);
        end
        do_reset();
        tests_run++;
        if (REDIRECT_CNT !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL cnt_clear: got %0d, required 0", REDIRECT_CNT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall_hold();
        test_redirect();
        test_wrap();
        test_timeout();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that owns the program counter and feeds decode plus the branch-target ALU.
- Issues sequential word fetches to instruction memory over a request/ack handshake.
- Captures returned instructions into the IF/ID register and honours decode stalls.
- Takes the resolved next-PC from the branch ALU on redirect (branch/jump/jr), flushing the wrong-path instruction.

Parameters:
RESET_PC, 16'h0000, first fetch address after reset
MAX_WAIT, 15, consecutive unacknowledged request cycles before fetch error (1..255)

Ports:
CLK  in  1  clock; all state changes on rising edge
RST  in  1  synchronous, active-high reset
NEXT_PC  in  16  resolved target from branch ALU (PC+1±offset or RS)
REDIRECT  in  1  decode resolved a taken branch/jump/jr this cycle; use NEXT_PC
STALL  in  1  decode cannot accept a new instruction this cycle
IMEM_REQ  out  1  fetch request valid
IMEM_ADDR  out  16  word address of request (= FETCH_PC)
IMEM_RDATA  in  16  instruction word, valid with IMEM_ACK
IMEM_ACK  in  1  memory returns data for the address presented this same cycle
PC  out  16  PC of instruction held in IF/ID (drives branch ALU PC input)
INSTR  out  16  instruction held in IF/ID
INSTR_VALID  out  1  IF/ID holds a valid instruction
FETCH_ERR  out  1  sticky fetch timeout flag

Behaviour:
- Reset (RST=1 at edge): state=BOOT, FETCH_PC=RESET_PC, PC=0, INSTR=0, INSTR_VALID=0, IMEM_REQ=0, hold reg cleared, wait counter=0, FETCH_ERR=0.
- States: BOOT, FETCH, HOLD, ERROR.
- BOOT: one cycle, IMEM_REQ=0; next state FETCH.
- FETCH: IMEM_REQ=1, IMEM_ADDR=FETCH_PC.
  - Memory contract: ack is combinational to the address presented in that cycle; address may change between any two cycles.
- IF/ID accept condition: INSTR_VALID=0 or STALL=0.
- FETCH with IMEM_ACK=1 and accept:
  - PC<=FETCH_PC, INSTR<=IMEM_RDATA, INSTR_VALID<=1, FETCH_PC<=FETCH_PC+1.
  - Stay in FETCH; throughput is one instruction per cycle with zero-wait memory.
- FETCH with IMEM_ACK=1 and no accept:
  - hold reg<=IMEM_RDATA, FETCH_PC unchanged, go HOLD.
- FETCH with IMEM_ACK=0 and accept: INSTR_VALID<=0 (decode consumed the previous instruction); otherwise IF/ID unchanged.
- HOLD: IMEM_REQ=0. When STALL=0: PC<=FETCH_PC, INSTR<=hold, INSTR_VALID<=1, FETCH_PC<=FETCH_PC+1, go FETCH.
- REDIRECT=1 (in BOOT/FETCH/HOLD) overrides everything above, including STALL and a same-cycle ACK:
  - FETCH_PC<=NEXT_PC, INSTR_VALID<=0, hold discarded, wait counter<=0, go FETCH.
  - The ACKed word in that cycle is dropped.
- Wait counter:
  - Increments each FETCH cycle with IMEM_REQ=1 and IMEM_ACK=0.
  - Clears on ACK, redirect, or leaving FETCH.
  - On reaching MAX_WAIT: go ERROR, FETCH_ERR<=1.
- ERROR: IMEM_REQ=0, INSTR_VALID<=0, REDIRECT ignored; exit only via RST.
- FETCH_PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000.
- RST asserted mid-request or in HOLD: reset values apply next edge; any outstanding ack is ignored.
- Decode-to-fetch redirect latency: first request to NEXT_PC issued the cycle after REDIRECT.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output REDIRECT_CNT (16 bits), counting cycles with REDIRECT=1 in a non-ERROR state.
  - Saturates at 16'hFFFF; cleared by RST.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset, then zero-wait memory (ACK tied 1, RDATA=addr^16'hA5A5).
   - IMEM_REQ rises the cycle after BOOT.
   - INSTR_VALID=1 with PC=0000, 0001, 0002 on consecutive cycles.
   - INSTR matches the RDATA rule.
2. STALL=1 for 3 cycles while an ACK arrives.
   - FSM enters HOLD, IMEM_REQ=0, PC/INSTR frozen.
   - After STALL drops, the held word appears with PC=old+1 and no word is lost or duplicated.
3. REDIRECT=1, NEXT_PC=0x0040, concurrent with STALL=1 and ACK=1.
   - INSTR_VALID=0 next cycle; IMEM_ADDR=0x0040.
   - Following valid instruction has PC=0x0040; the dropped word never appears.
4. RESET_PC=16'hFFFE with zero-wait memory.
   - Valid PCs are FFFE, FFFF, 0000 (wrap).
5. ACK held 0 with MAX_WAIT=4.
   - FETCH_ERR=1 after 4 request cycles; IMEM_REQ=0.
   - A subsequent REDIRECT is ignored; RST clears FETCH_ERR and restarts at RESET_PC.
6. With FETCH_PERF_CNT_EN defined: 5 redirect pulses.
   - REDIRECT_CNT=5; stays 5 while in ERROR; resets to 0 on RST.
